// File: rtl/instruction_fetch_queue.sv
// Fetch stage: sequential address generation, single-cycle imem handshake and a
// small circular prefetch queue feeding decode, with redirect flush.
module instruction_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze_cpu,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid
);

    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0]  CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [31:0]  NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_r;
    logic [31:0]   pc_mem_r   [DEPTH];
    logic [31:0]   word_mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [AW:0]   count_r;
    logic          push_s;
    logic          pop_s;

    assign push_s    = imem_req && imem_ready;
    assign pop_s     = inst_valid && !freeze_cpu;
    assign imem_addr = fetch_pc_r;

    // Request generation and head-entry presentation; outputs forced to idle during reset.
    always_comb begin
        imem_req   = 1'b0;
        inst       = NOP;
        inst_pc    = 32'h0000_0000;
        inst_valid = 1'b0;
        if (!rst && !redirect && (count_r < DEPTH_C)) begin
            imem_req = 1'b1;
        end else begin
            imem_req = 1'b0;
        end
        if (!rst && (count_r != {(AW+1){1'b0}})) begin
            inst       = word_mem_r[head_r];
            inst_pc    = pc_mem_r[head_r];
            inst_valid = 1'b1;
        end else begin
            inst       = NOP;
            inst_pc    = 32'h0000_0000;
            inst_valid = 1'b0;
        end
    end

    // Control state: reset beats redirect, redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
            head_r     <= {AW{1'b0}};
            tail_r     <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
        end else if (redirect) begin
            fetch_pc_r <= redirect_pc & 32'hFFFF_FFFC;
            head_r     <= {AW{1'b0}};
            tail_r     <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                tail_r     <= tail_r + PTR_ONE;
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (!push_s && pop_s) begin
                count_r <= count_r - CNT_ONE;
            end
        end
    end

    // Queue storage; push is already suppressed under reset and redirect.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_r[tail_r]   <= fetch_pc_r;
            word_mem_r[tail_r] <= imem_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomized bench for instruction_fetch_queue checked against a queue-based
// reference model of the fetch/prefetch behaviour.
module tb_instruction_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze_cpu;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_fpc;

    always #5 clk = ~clk;

    // instruction memory: data is a function of the address, garbage when not accepted
    assign imem_data = (imem_req && imem_ready) ? (imem_addr ^ KEY) : 32'hDEAD_BEEF;

    instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze_cpu  (freeze_cpu),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // compare outputs with the model, then advance both across one clock edge
    task automatic cycle(input logic r, input logic frz, input logic rdy,
                         input logic rdr, input logic [31:0] rpc);
        logic exp_req;
        logic do_push;
        logic do_pop;
        rst = r; freeze_cpu = frz; imem_ready = rdy; redirect = rdr; redirect_pc = rpc;
        @(negedge clk);
        exp_req = !r && !rdr && (mq.size() < DEPTH);
        check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        check_eq("imem_addr", imem_addr, m_fpc);
        if (!r && mq.size() > 0) begin
            check_eq("inst", inst, mq[0].word);
            check_eq("inst_pc", inst_pc, mq[0].pc);
            check_eq("inst_valid", {31'd0, inst_valid}, 32'd1);
        end else begin
            check_eq("inst", inst, NOP);
            check_eq("inst_pc", inst_pc, 32'd0);
            check_eq("inst_valid", {31'd0, inst_valid}, 32'd0);
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_fpc = RESET_PC;
        end else if (rdr) begin
            mq.delete();
            m_fpc = {rpc[31:2], 2'b00};
        end else begin
            do_push = (mq.size() < DEPTH) && rdy;
            do_pop  = (mq.size() > 0) && !frz;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{pc: m_fpc, word: m_fpc ^ KEY});
                m_fpc = m_fpc + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; freeze_cpu = 1'b0; imem_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
        m_fpc = 32'd0;
        @(posedge clk);
        #1;
        m_fpc = RESET_PC;
        // reset, then free-running stream across the address wrap
        repeat (3) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        repeat (20) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        // decode frozen long enough to fill the queue
        repeat (10) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        check_eq("full_count", mq.size(), DEPTH);
        repeat (8) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        // memory stalls while draining
        repeat (3) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
            cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        end
        // build 3 entries, then redirect with a misaligned target
        repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        // redirect together with reset: reset wins
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_4000);
        repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = $urandom;
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), rpc);
        end
        // reset with a full, frozen queue
        repeat (8) cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
        repeat (6) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch stage directly upstream of instruction decode. It generates sequential instruction addresses, requests words from the instruction memory over a single-cycle ready handshake, and buffers them in a small prefetch queue. Decode pops one instruction per unfrozen cycle. When the queue is empty, decode is fed a NOP (`addi x0,x0,0`, 32'h00000013). A redirect from a later stage flushes the queue and restarts fetch at a new address.

## Interface
Parameters:
- `DEPTH`, default 4: number of queue entries; must be a power of two, ≥ 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `freeze_cpu`  in  1: pipeline stall from the cache. While high, the head entry is not consumed.
- `redirect`  in  1: taken branch or jump; flush and refetch.
- `redirect_pc`  in  32: new fetch address; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch address, word aligned.
- `imem_ready`  in  1: memory accepts the request and returns data in the same cycle.
- `imem_data`  in  32: instruction word; valid only when `imem_req && imem_ready`.
- `inst`  out  32: instruction presented to decode; the NOP when the queue is empty.
- `inst_pc`  out  32: address of `inst`; 0 when the queue is empty.
- `inst_valid`  out  1: 1 when `inst` comes from the queue rather than being the NOP bubble.

## Operation
- State:
  - `fetch_pc` (32 bits).
  - Circular queue of `DEPTH` entries, each {pc, word}.
  - `head` and `tail` pointers, log2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`, log2(DEPTH)+1 bits, range 0..DEPTH.
- Request: `imem_req = !rst && !redirect && (count < DEPTH)`, with `imem_addr = fetch_pc`.
  - The request does not depend on a same-cycle pop, so a full queue issues no request even while popping.
- Push (accept) when `imem_req && imem_ready`:
  - write {fetch_pc, imem_data} at `tail`;
  - `tail += 1`;
  - `fetch_pc += 4` (32-bit wrap, 32'hFFFF_FFFC → 0).
- Pop when `inst_valid && !freeze_cpu`: `head += 1`.
- `count` update:
  - push only: `count += 1`;
  - pop only: `count -= 1`;
  - push and pop together: unchanged.
- Output: `inst`, `inst_pc` and `inst_valid` are combinational from the head entry and `count != 0`; there is no bypass from `imem_data`.
- Redirect has priority over push and pop. On the edge it sets `head = tail = count = 0` and `fetch_pc = {redirect_pc[31:2], 2'b00}`.
  - No request is issued in the redirect cycle, so no stale word can be pushed.
- Reset has priority over everything: `fetch_pc = RESET_PC`, pointers and `count` cleared. Queue contents need not be cleared.
- The instruction word is not inspected or decoded in this block.

## Timing
- Reset values, held while `rst` is high:
  - `imem_req` = 0
  - `inst` = 32'h00000013
  - `inst_pc` = 0
  - `inst_valid` = 0
- First request is in the first cycle after `rst` falls, with `imem_addr = RESET_PC`.
- Latency: a word accepted at edge N is on `inst` in cycle N+1. Steady-state throughput is 1 instruction per cycle with `imem_ready` held high.
- `imem_ready` low: the request and address hold steady and `fetch_pc` is unchanged. The memory may stall any number of cycles.
- Full (`count == DEPTH`): `imem_req` = 0. It reasserts in the cycle after the first pop.
- Empty: the NOP is presented with `inst_valid` = 0. `freeze_cpu` has no effect on state.
- `freeze_cpu` high with a non-empty queue: `inst`, `inst_pc` and `inst_valid` hold; pushes continue until full.
- Redirect at edge N: queue empty in cycle N+1 (NOP output) and a request at the new address in N+1. The earliest new instruction reaches decode in N+2.
- `redirect` together with `rst`: reset wins. `redirect` together with `freeze_cpu`: redirect still flushes.
- Reset mid-operation: any accepted-but-unconsumed entries are discarded. Fetch restarts at `RESET_PC` after release.

## Test plan
- Reset then `imem_ready`=1 constant, memory returning word = address ^ 32'hA5A5_0000 → `inst_pc` sequence 0,4,8,… from the 2nd cycle after reset, one per cycle, `inst_valid`=1 continuously.
- `freeze_cpu`=1 for 10 cycles in the middle of the stream → `inst_pc` holds, `count` reaches 4, `imem_req`=0, `fetch_pc` holds at head_pc+16. After release the stream resumes with no skipped or duplicated address.
- `imem_ready` toggling 1,0,0,1 with the queue draining → NOP with `inst_valid`=0 appears on starvation cycles; `imem_addr` is stable while not ready.
- `redirect`=1 with `redirect_pc`=32'h0000_0103 while 3 entries are queued and `imem_ready`=1 → next cycle NOP, `imem_addr`=32'h100. The old entries never reach `inst`, and `inst_pc`=32'h100 appears one cycle later.
- `RESET_PC`=32'hFFFF_FFF8 → fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap-around).
- `rst` asserted with a full queue and `freeze_cpu`=1 → outputs at their reset values during reset; the first `imem_addr` after release equals `RESET_PC`.
